// File: rtl/dbus_mailbox.sv
// Data-port register window with a word FIFO mailbox.
// Word stores to DATA are queued and drained over a valid/ready stream.
module dbus_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int          DEPTH     = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DREQ,
  input  logic [31:0] DADDR,
  input  logic        DRW,
  input  logic [1:0]  DSIZE,
  input  logic [31:0] DOUT,
  output logic [31:0] DIN,
  output logic        MB_VALID,
  output logic [31:0] MB_DATA,
  input  logic        MB_READY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    R_DATA, R_STATUS, R_SCR, R_CTRL
  } reg_e;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [7:0]    drop_q, drop_d;
  logic [31:0]   scr_q, scr_d;
  logic [31:0]   din_q, din_d;

  logic        hit, empty, full;
  logic        push, push_ok, pop, drop;
  logic        ctrl_wr, flush, clr, err_set;
  logic [3:0]  be;
  logic [31:0] status, rdata;
  reg_e        sel;

  assign hit   = DREQ && (DADDR[31:4] == BASE_ADDR[31:4]);
  assign sel   = reg_e'(DADDR[3:2]);
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    be = 4'h0;
    case ({DSIZE, DADDR[1:0]})
      4'b00_00: be = 4'h1;
      4'b00_01: be = 4'h2;
      4'b00_10: be = 4'h4;
      4'b00_11: be = 4'h8;
      4'b01_00: be = 4'h3;
      4'b01_10: be = 4'hC;
      4'b10_00: be = 4'hF;
      default:  be = 4'h0;
    endcase
  end

  assign push    = hit && DRW && (sel == R_DATA) && (be == 4'hF);
  assign pop     = !empty && MB_READY;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign ctrl_wr = hit && DRW && (sel == R_CTRL)
                && ((be == 4'hF) || (be == 4'h1));
  assign flush   = ctrl_wr && DOUT[0];
  assign clr     = ctrl_wr && DOUT[1];
  assign err_set = hit && ((be == 4'h0)
                || (DRW && (sel == R_DATA) && (be != 4'hF)));

  assign MB_VALID = !empty;
  assign MB_DATA  = empty ? 32'h0 : mem_q[rd_q];
  assign DIN      = din_q;

  assign status = {8'h0, drop_q, 4'h0, err_q, ovf_q,
                   full, empty, 8'(cnt_q)};

  always_comb begin
    rdata = 32'h0;
    case (sel)
      R_DATA:   rdata = MB_DATA;
      R_STATUS: rdata = status;
      R_SCR:    rdata = scr_q;
      default:  rdata = 32'h0;
    endcase
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    drop_d = drop_q;
    scr_d  = scr_q;
    din_d  = din_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop)     rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    end
    if (clr) begin
      ovf_d  = 1'b0;
      err_d  = 1'b0;
      drop_d = 8'h0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'h1;
    end
    if (err_set) err_d = 1'b1;
    if (hit && DRW && (sel == R_SCR)) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) scr_d[8*i +: 8] = DOUT[8*i +: 8];
    end
    if (hit && !DRW) din_d = rdata;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      drop_q <= 8'h0;
      scr_q  <= 32'h0;
      din_q  <= 32'h0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
      drop_q <= drop_d;
      scr_q  <= scr_d;
      din_q  <= din_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_q] <= DOUT;
  end

endmodule

// File: tb/tb_dbus_mailbox.sv
// Directed bench for dbus_mailbox.
// Accesses are driven on the falling edge and checked on the next one.
module tb_dbus_mailbox;

  localparam logic [31:0] A_DATA = 32'h0000_4000;
  localparam logic [31:0] A_STAT = 32'h0000_4004;
  localparam logic [31:0] A_SCR  = 32'h0000_4008;
  localparam logic [31:0] A_CTRL = 32'h0000_400C;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        DREQ = 1'b0;
  logic [31:0] DADDR = '0;
  logic        DRW = 1'b0;
  logic [1:0]  DSIZE = 2'b10;
  logic [31:0] DOUT = '0;
  logic [31:0] DIN;
  logic        MB_VALID;
  logic [31:0] MB_DATA;
  logic        MB_READY = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] rv;

  dbus_mailbox dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DADDR(DADDR),
    .DRW(DRW), .DSIZE(DSIZE), .DOUT(DOUT), .DIN(DIN),
    .MB_VALID(MB_VALID), .MB_DATA(MB_DATA), .MB_READY(MB_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic acc(input logic rw, input logic [31:0] a,
                     input logic [1:0] sz, input logic [31:0] d);
    DREQ = 1'b1; DRW = rw; DADDR = a; DSIZE = sz; DOUT = d;
    @(negedge CLK);
    DREQ = 1'b0; DRW = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    acc(1'b1, a, 2'b10, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    acc(1'b0, a, 2'b10, 32'h0);
    v = DIN;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_din", DIN, 32'h0);
    chk("rst_valid", {31'h0, MB_VALID}, 32'h0);
    RESET_N = 1'b1;
    @(negedge CLK);
    rd(A_STAT, rv);
    chk("rst_status", rv, 32'h0000_0100);
    chk("rst_mbdata", MB_DATA, 32'h0);

    wr(A_DATA, 32'h11);
    wr(A_DATA, 32'h22);
    wr(A_DATA, 32'h33);
    wr(32'h0000_4010, 32'h44);
    rd(A_STAT, rv);
    chk("status3", rv, 32'h0000_0003);
    chk("head11", MB_DATA, 32'h11);
    rd(32'h0000_5004, rv);
    chk("miss_hold", rv, 32'h0000_0003);
    rd(A_DATA, rv);
    chk("peek", rv, 32'h11);
    MB_READY = 1'b1;
    chk("pop0", MB_DATA, 32'h11);
    @(negedge CLK);
    chk("pop1", MB_DATA, 32'h22);
    @(negedge CLK);
    chk("pop2", MB_DATA, 32'h33);
    @(negedge CLK);
    chk("drained", {31'h0, MB_VALID}, 32'h0);
    MB_READY = 1'b0;
    rd(A_DATA, rv);
    chk("empty_read", rv, 32'h0);

    for (int i = 1; i <= 9; i++) wr(A_DATA, 32'(i));
    rd(A_STAT, rv);
    chk("overflow", rv, 32'h0001_0608);
    wr(A_CTRL, 32'h3);
    rd(A_STAT, rv);
    chk("flush_clr", rv, 32'h0000_0100);

    wr(A_SCR, 32'h0);
    acc(1'b1, A_SCR + 1, 2'b00, 32'h0000_AB00);
    acc(1'b1, A_SCR + 2, 2'b01, 32'hCDEF_0000);
    rd(A_SCR, rv);
    chk("scratch", rv, 32'hCDEF_AB00);
    acc(1'b1, A_SCR + 1, 2'b01, 32'h1234_5678);
    rd(A_SCR, rv);
    chk("scr_misalign", rv, 32'hCDEF_AB00);
    rd(A_STAT, rv);
    chk("err_flag", rv, 32'h0000_0900);
    wr(A_CTRL, 32'h2);
    rd(A_STAT, rv);
    chk("err_clr", rv, 32'h0000_0100);

    for (int i = 0; i < 8; i++) wr(A_DATA, 32'hA0 + 32'(i));
    chk("full_valid", {31'h0, MB_VALID}, 32'h1);
    MB_READY = 1'b1;
    wr(A_DATA, 32'h99);
    MB_READY = 1'b0;
    rd(A_STAT, rv);
    chk("pushpop", rv, 32'h0000_0208);
    MB_READY = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("order%0d", i), MB_DATA, 32'hA0 + 32'(i));
      @(negedge CLK);
    end
    chk("last99", MB_DATA, 32'h99);
    @(negedge CLK);
    chk("empty2", {31'h0, MB_VALID}, 32'h0);
    MB_READY = 1'b0;

    wr(A_DATA, 32'h1);
    wr(A_DATA, 32'h2);
    wr(A_DATA, 32'h3);
    rd(A_STAT, rv);
    chk("pre_rst", rv, 32'h0000_0003);
    MB_READY = 1'b1;
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_mid_valid", {31'h0, MB_VALID}, 32'h0);
    chk("rst_mid_din", DIN, 32'h0);
    chk("rst_mid_data", MB_DATA, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    MB_READY = 1'b0;
    rd(A_STAT, rv);
    chk("rst_mid_stat", rv, 32'h0000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_mailbox.md
# dbus_mailbox

Memory-mapped responder on the CortexM0 data-memory port: accepts core loads/stores addressed to a 16-byte register window and answers with one-cycle synchronous read data, exactly like the data SRAM. Word stores to the DATA register are queued in a FIFO that an external consumer drains over a valid/ready stream, giving test programs an ordered result channel alongside plain SRAM stores. Byte-lane decode from DSIZE/DADDR[1:0] is done locally, and misaligned or sub-word accesses are flagged.

## Interface
- BASE_ADDR, 32'h0000_4000: window base; only bits [31:4] compared.
- DEPTH, 8: FIFO entries; power of two, 2..128.
- CLK  in  1  single clock, all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  in  1  core data request, one access per cycle.
- DADDR  in  32  byte address.
- DRW  in  1  1 = write, 0 = read.
- DSIZE  in  2  00 byte, 01 half, 10 word.
- DOUT  in  32  core write data (lane-positioned).
- DIN  out  32  read data to core.
- MB_VALID  out  1  FIFO non-empty.
- MB_DATA  out  32  FIFO head word; 0 when empty.
- MB_READY  in  1  consumer accepts head.

## Operation
- Hit = DREQ && DADDR[31:4]==BASE_ADDR[31:4]; DADDR[3:2] selects: 0 DATA, 1 STATUS, 2 SCRATCH, 3 CTRL. Non-hit: no state change, DIN unchanged.
- Lane enables: byte -> one-hot by DADDR[1:0]; half at 00 -> 0011, at 10 -> 1100; word at 00 -> 1111; any other combination (misaligned, DSIZE=11) -> 0000 and ERR set.
- DATA write: push DOUT only when DSIZE=10 and aligned; sub-word DATA write ignored, sets ERR. DATA read: peek head (no pop), 0 if empty.
- STATUS (read-only, writes ignored): [7:0] count, [8] empty, [9] full, [10] OVF, [11] ERR, [23:16] drop count, others 0.
- SCRATCH: 32-bit R/W, per-lane write by enables.
- CTRL write, word or byte lane 0: bit0=1 flush FIFO (pointers, count to 0); bit1=1 clear OVF, ERR, drop count. CTRL reads 0.
- Drain: pop when MB_VALID && MB_READY.
- Push while full without pop: data dropped, OVF sticky set, drop count +1, saturating at 255.
- Push and pop same edge: both occur, count unchanged; valid also when full (push accepted).
- Flush and pop same edge: flush wins. Flush and push cannot coincide (single port).
- ERR set and CTRL clear in same access impossible; ERR from misaligned CTRL write is set, clear not applied.

## Timing
- Reset (async, RESET_N low): DIN=0, MB_VALID=0, MB_DATA=0, count=0, OVF=ERR=0, drop count=0, SCRATCH=0. Reset mid-operation discards FIFO contents immediately.
- Writes take effect at the edge where DREQ is sampled high.
- Read latency 1: DIN registered at the edge sampling the read; valid in the following cycle; held until next hit read.
- Reads return pre-edge state: a read on the same edge as a push/pop/flush sees the old value; next-cycle read sees the update.
- MB_VALID/MB_DATA driven from registered state; a word pushed at edge N is visible on MB_DATA after edge N, poppable at edge N+1.
- Back-to-back accesses every cycle supported, no wait states.

## Test plan
- Reset release, read STATUS -> DIN=32'h0000_0100 (empty, count 0); MB_VALID=0.
- MB_READY=0, store 0x11,0x22,0x33 words to DATA -> STATUS=0x0000_0003, MB_DATA=0x11; then MB_READY=1 three cycles -> MB_DATA 0x11,0x22,0x33 in order, then MB_VALID=0.
- MB_READY=0, nine word pushes with DEPTH=8 -> STATUS count 8, full, OVF, drop count 1 (0x0001_0608); write CTRL=0x3 -> STATUS=0x0000_0100.
- SCRATCH: word write 0x0, byte 0xAB at +1, half 0xCDEF at +2 -> read SCRATCH = 0xCDEF_AB00; half write at +1 -> no change, ERR set (STATUS bit11).
- Full FIFO, MB_READY=1 and simultaneous word push 0x99 -> count stays 8, OVF stays 0, 0x99 appears last.
- Assert RESET_N low mid-drain with 3 entries queued -> MB_VALID, DIN, count immediately 0, no further pops.
